// File: rtl/decode_stage_if.sv
// decode_stage_if: handshake and decoded-field bundle between fetch, decode and execute
//   master: flush, in_valid, instr_in, pc_in, out_ready (fetch/execute side)
//   slave : in_ready, out_valid, pc_out, opcode, rd, rs1, rs2, funct3, funct7,
//           imm, itype, reg_we, illegal (decode side)
interface decode_stage_if #(parameter int PC_W = 12);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr_in;
    logic [PC_W-1:0] pc_in;
    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] pc_out;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [31:0]     imm;
    logic [2:0]      itype;
    logic            reg_we;
    logic            illegal;

    modport master (
        output flush, in_valid, instr_in, pc_in, out_ready,
        input  in_ready, out_valid, pc_out, opcode, rd, rs1, rs2, funct3, funct7,
               imm, itype, reg_we, illegal
    );

    modport slave (
        input  flush, in_valid, instr_in, pc_in, out_ready,
        output in_ready, out_valid, pc_out, opcode, rd, rs1, rs2, funct3, funct7,
               imm, itype, reg_we, illegal
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode with a DEPTH-entry skid buffer of pre-decoded entries
//   clk, rst : clock, asynchronous active-high reset
//   bus      : decode_stage_if.slave (fetch handshake in, decoded head entry out)
//   DECODE_ILLEGAL_DETECT_EN : when defined, unmapped opcodes raise illegal
module decode_stage #(
    parameter int PC_W  = 12,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave bus
);
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [31:0]     imm;
        logic [2:0]      itype;
        logic            reg_we;
        logic            illegal;
    } entry_t;

    localparam logic [0:0] LAST = 1'(DEPTH - 1);

    entry_t     mem [DEPTH];
    entry_t     head;
    logic [0:0] rd_ptr, wr_ptr, sel;
    logic [1:0] count;
    logic       acc, con;

    function automatic logic [0:0] nxt(input logic [0:0] p);
        return (p == LAST) ? 1'b0 : p + 1'b1;
    endfunction

    function automatic logic [0:0] prv(input logic [0:0] p);
        return (p == 1'b0) ? LAST : p - 1'b1;
    endfunction

    function automatic entry_t decode(input logic [31:0] i, input logic [PC_W-1:0] pc);
        entry_t e;
        logic   wr;
        e        = '0;
        wr       = 1'b1;
        e.pc     = pc;
        e.opcode = i[6:0];
        e.rd     = i[11:7];
        e.rs1    = i[19:15];
        e.rs2    = i[24:20];
        e.funct3 = i[14:12];
        e.funct7 = i[31:25];
        case (i[6:0])
            7'b0110011: e.itype = 3'd0;
            7'b0010011: begin e.itype = 3'd1; e.imm = {{20{i[31]}}, i[31:20]}; end
            7'b0000011: begin e.itype = 3'd2; e.imm = {{20{i[31]}}, i[31:20]}; end
            7'b0100011: begin e.itype = 3'd3; e.imm = {{20{i[31]}}, i[31:25], i[11:7]}; wr = 1'b0; end
            7'b1100011: begin
                e.itype = 3'd4;
                e.imm   = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
                wr      = 1'b0;
            end
            7'b1101111: begin e.itype = 3'd5; e.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}; end
            7'b1100111: begin e.itype = 3'd6; e.imm = {{20{i[31]}}, i[31:20]}; end
            7'b0110111,
            7'b0010111: begin e.itype = 3'd7; e.imm = {i[31:12], 12'b0}; end
            default: begin
                // unmapped opcodes (including any with i[1:0] != 2'b11) behave as a NOP
                e.itype = 3'd1;
                wr      = 1'b0;
`ifdef DECODE_ILLEGAL_DETECT_EN
                e.illegal = 1'b1;
`endif
            end
        endcase
        e.reg_we = wr & (i[11:7] != 5'd0);
        return e;
    endfunction

    assign bus.out_valid = count != 2'd0;
    assign con           = bus.out_valid & bus.out_ready;
    // a consume while full frees the slot the accept writes into
    assign bus.in_ready  = ~rst & ((count < 2'(DEPTH)) | con);
    assign acc           = bus.in_valid & bus.in_ready;

    // when empty, show the most recently consumed slot so outputs hold their last values
    assign sel  = bus.out_valid ? rd_ptr : prv(rd_ptr);
    assign head = mem[sel];

    assign bus.pc_out  = head.pc;
    assign bus.opcode  = head.opcode;
    assign bus.rd      = head.rd;
    assign bus.rs1     = head.rs1;
    assign bus.rs2     = head.rs2;
    assign bus.funct3  = head.funct3;
    assign bus.funct7  = head.funct7;
    assign bus.imm     = head.imm;
    assign bus.itype   = head.itype;
    assign bus.reg_we  = head.reg_we;
    assign bus.illegal = head.illegal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
        end else if (bus.flush) begin
            count  <= '0;
            wr_ptr <= rd_ptr;
        end else begin
            if (acc) begin
                mem[wr_ptr] <= decode(bus.instr_in, bus.pc_in);
                wr_ptr      <= nxt(wr_ptr);
            end
            if (con) rd_ptr <= nxt(rd_ptr);
            count <= count + {1'b0, acc} - {1'b0, con};
        end
    end
endmodule
